// File: rtl/removal_sequencer.sv
// removal_sequencer
//   Holds a WIDTH x DEPTH occupancy grid loaded row by row, then drives an
//   external removal datapath pass after pass. The run ends when a pass removes
//   nothing or when MAX_PASSES passes have removed something. Each accepted
//   pass result replaces the stored grid and adds to the running total.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   row_valid/row_ready/row_data    row load handshake (rows 0..DEPTH-1 in order)
//   start                           begin a run on a fully loaded grid
//   busy, done                      run in progress / run finished (level)
//   total_removed, pass_count, err  run results (err: pass limit or saturation)
//   eval_req, eval_grid             request and grid offered to the datapath
//   eval_ack, eval_next_grid,
//   eval_removed, eval_any          datapath result for the current request
//   grid_rd_row, grid_rd_data       combinational readback of one stored row
module removal_sequencer #(
  parameter  int WIDTH      = 16,
  parameter  int DEPTH      = 16,
  parameter  int MAX_PASSES = 64,
  localparam int CW         = $clog2(WIDTH*DEPTH+1),
  localparam int PW         = $clog2(MAX_PASSES+1),
  localparam int RW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [WIDTH-1:0]       row_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          total_removed,
  output logic [PW-1:0]          pass_count,
  output logic                   err,
  output logic                   eval_req,
  output logic [WIDTH*DEPTH-1:0] eval_grid,
  input  logic                   eval_ack,
  input  logic [WIDTH*DEPTH-1:0] eval_next_grid,
  input  logic [CW-1:0]          eval_removed,
  input  logic                   eval_any,
  input  logic [RW-1:0]          grid_rd_row,
  output logic [WIDTH-1:0]       grid_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] grid_reg [DEPTH];
  logic [RW-1:0]    row_cnt_reg;
  logic             loaded_reg;
  logic [CW-1:0]    total_reg;
  logic [PW-1:0]    pass_reg;
  logic             err_reg;

  logic             row_accept;
  logic             start_ok;
  logic [CW:0]      sum_next;

  // Status outputs are plain decodes of the state register.
  assign row_ready = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_EVAL) || (state_reg == ST_UPDATE);
  assign done      = (state_reg == ST_DONE);
  assign eval_req  = (state_reg == ST_EVAL);

  assign total_removed = total_reg;
  assign pass_count    = pass_reg;
  assign err           = err_reg;

  assign row_accept = row_valid && row_ready;
  // loaded_reg is the pre-edge value, so a start arriving with the row that
  // completes the very first load is ignored.
  assign start_ok   = start && row_ready && loaded_reg;

  // One extra bit catches overflow of the running total.
  assign sum_next = {1'b0, total_reg} + {1'b0, eval_removed};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign eval_grid[gi*WIDTH +: WIDTH] = grid_reg[gi];
    end
  endgenerate

  assign grid_rd_data = (32'(grid_rd_row) < DEPTH) ? grid_reg[grid_rd_row] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) grid_reg[i] <= '0;
      row_cnt_reg <= '0;
      loaded_reg  <= 1'b0;
      total_reg   <= '0;
      pass_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      // Rows are only accepted in IDLE/DONE, so they never collide with the
      // pass-result write below.
      if (row_accept) begin
        grid_reg[row_cnt_reg] <= row_data;
        if (row_cnt_reg == RW'(DEPTH-1)) begin
          row_cnt_reg <= '0;
          loaded_reg  <= 1'b1;
        end else begin
          row_cnt_reg <= row_cnt_reg + RW'(1);
        end
      end

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            total_reg <= '0;
            pass_reg  <= '0;
            err_reg   <= 1'b0;
            state_reg <= ST_EVAL;
          end else if (row_accept) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_EVAL: begin
          if (eval_ack) begin
            pass_reg <= pass_reg + PW'(1);
            if (eval_any) begin
              for (int i = 0; i < DEPTH; i++)
                grid_reg[i] <= eval_next_grid[i*WIDTH +: WIDTH];
              if (sum_next[CW]) begin
                total_reg <= '1;
                err_reg   <= 1'b1;
              end else begin
                total_reg <= sum_next[CW-1:0];
              end
              state_reg <= ST_UPDATE;
            end else begin
              state_reg <= ST_DONE;
            end
          end
        end

        ST_UPDATE: begin
          if (pass_reg == PW'(MAX_PASSES)) begin
            err_reg   <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            state_reg <= ST_EVAL;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_removal_sequencer.sv
// Bench for removal_sequencer (4x4 grid, 3-pass limit). The bench plays the
// removal datapath itself: a roll is removed when fewer than four of its eight
// neighbours hold rolls. A run-level model predicts totals, pass count and err
// from the grid at start; a per-cycle compare process checks status levels,
// the offered grid and the readback port against the bench's own grid image.
module tb_removal_sequencer;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int MP = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        row_valid;
  logic        row_ready;
  logic [3:0]  row_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  total_removed;
  logic [1:0]  pass_count;
  logic        err;
  logic        eval_req;
  logic [15:0] eval_grid;
  logic        eval_ack;
  logic [15:0] eval_next_grid;
  logic [4:0]  eval_removed;
  logic        eval_any;
  logic [1:0]  grid_rd_row;
  logic [3:0]  grid_rd_data;

  removal_sequencer #(.WIDTH(W), .DEPTH(D), .MAX_PASSES(MP)) dut (
    .clk(clk), .rst_n(rst_n),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .start(start), .busy(busy), .done(done),
    .total_removed(total_removed), .pass_count(pass_count), .err(err),
    .eval_req(eval_req), .eval_grid(eval_grid), .eval_ack(eval_ack),
    .eval_next_grid(eval_next_grid), .eval_removed(eval_removed), .eval_any(eval_any),
    .grid_rd_row(grid_rd_row), .grid_rd_data(grid_rd_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [15:0] exp_grid = '0;
  int          m_ptr    = 0;
  bit          m_loaded = 0;
  int          phase    = 0;    // 0 idle, 1 running, 2 done
  bit          tot_chk  = 1;
  int          exp_total = 0;
  int          exp_passes = 0;
  bit          exp_err  = 0;
  bit          rd_force = 0;
  logic [1:0]  rd_val   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbrs(input logic [15:0] g, input int r, input int c);
    int n;
    int rr;
    int cc;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < D && cc >= 0 && cc < W)
          if (g[rr*W+cc]) n++;
      end
    return n;
  endfunction

  function automatic logic [15:0] strip(input logic [15:0] g);
    logic [15:0] o;
    o = g;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < W; c++)
        if (g[r*W+c] && nbrs(g, r, c) < 4) o[r*W+c] = 1'b0;
    return o;
  endfunction

  function automatic int n_access(input logic [15:0] g);
    int n;
    n = 0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < W; c++)
        if (g[r*W+c] && nbrs(g, r, c) < 4) n++;
    return n;
  endfunction

  // Whole-run prediction: mode 0 = reference datapath, mode 1 = stub that
  // always reports srem removals.
  function automatic void run_model(input logic [15:0] g0, input int mode, input int srem,
                                    output int tot, output int passes, output bit e);
    logic [15:0] g;
    int r;
    g = g0;
    tot = 0;
    passes = 0;
    e = 0;
    for (int p = 1; p <= MP; p++) begin
      passes = p;
      r = (mode == 0) ? n_access(g) : srem;
      if (r == 0) break;
      if (mode == 0) g = strip(g);
      tot += r;
      if (tot > 31) begin
        tot = 31;
        e = 1;
      end
      if (p == MP) e = 1;
    end
  endfunction

  // Readback row driver
  initial begin
    grid_rd_row = '0;
    forever begin
      @(posedge clk);
      #2;
      grid_rd_row = rd_force ? rd_val : 2'($urandom_range(0, 3));
    end
  end

  // Per-cycle compare process
  initial begin
    bit prev_req;
    logic [15:0] prev_grid;
    prev_req = 0;
    prev_grid = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("done_lvl", done, phase == 2);
        chk("busy_lvl", busy, phase == 1);
        chk("row_ready", row_ready, phase != 1);
        if (phase != 1) chk("req_idle", eval_req, 0);
        if (eval_req) begin
          chk("eval_grid", eval_grid, exp_grid);
          if (prev_req) chk("grid_stable", eval_grid, prev_grid);
        end
        chk("rd_data", grid_rd_data, exp_grid[grid_rd_row*W +: W]);
        if (tot_chk) begin
          chk("total", total_removed, exp_total);
          chk("passes", pass_count, exp_passes);
          chk("err", err, exp_err);
        end
        prev_req = eval_req;
        prev_grid = eval_grid;
      end else begin
        prev_req = 0;
      end
    end
  end

  // Serve a run that has just started (called at +1 after the start edge).
  task automatic serve_run(input int mode, input int srem, input int dmin, input int dmax);
    logic [15:0] nx;
    int rem;
    int dly;
    int acks;
    bit any;
    bit fin;
    acks = 0;
    fin = 0;
    run_model(exp_grid, mode, srem, exp_total, exp_passes, exp_err);
    while (!fin && acks <= MP) begin
      chk("req_rise", eval_req, 1);
      dly = $urandom_range(dmin, dmax);
      repeat (dly) begin
        @(posedge clk);
        #1;
      end
      if (mode == 0) begin
        nx = strip(exp_grid);
        rem = n_access(exp_grid);
      end else begin
        nx = 16'($urandom);
        rem = srem;
      end
      any = (rem != 0);
      eval_ack = 1'b1;
      eval_next_grid = nx;
      eval_removed = rem[4:0];
      eval_any = any;
      @(posedge clk);
      #1;
      acks++;
      eval_ack = 1'b0;
      if (any) exp_grid = nx;
      if (!any) begin
        phase = 2;
        tot_chk = 1;
        fin = 1;
      end else begin
        chk("gap_req", eval_req, 0);
        // An ack while no request is pending must be ignored.
        eval_ack = 1'($urandom_range(0, 1));
        eval_any = 1'b1;
        eval_removed = 5'd7;
        eval_next_grid = 16'($urandom);
        @(posedge clk);
        #1;
        eval_ack = 1'b0;
        if (acks == MP) begin
          phase = 2;
          tot_chk = 1;
          fin = 1;
        end
      end
    end
    if (!fin) chk("run_end", 0, 1);
  endtask

  task automatic load_row(input logic [3:0] d, input bit st, output bit hon);
    row_valid = 1'b1;
    row_data = d;
    start = st;
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    start = 1'b0;
    hon = st && m_loaded;
    exp_grid[m_ptr*W +: W] = d;
    if (m_ptr == D-1) m_loaded = 1;
    m_ptr = (m_ptr + 1) % D;
    tot_chk = 0;
    phase = hon ? 1 : 0;
  endtask

  task automatic load_grid(input logic [15:0] g);
    bit hon;
    for (int r = 0; r < D; r++) load_row(g[r*W +: W], 0, hon);
  endtask

  task automatic go(input int mode, input int srem, input int dmin, input int dmax);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (m_loaded) begin
      phase = 1;
      tot_chk = 0;
      serve_run(mode, srem, dmin, dmax);
    end
  endtask

  task automatic model_reset();
    phase = 0;
    exp_grid = '0;
    m_ptr = 0;
    m_loaded = 0;
    exp_total = 0;
    exp_passes = 0;
    exp_err = 0;
    tot_chk = 1;
  endtask

  initial begin
    bit hon;
    int n;
    rst_n = 1'b0;
    row_valid = 1'b0;
    row_data = '0;
    start = 1'b0;
    eval_ack = 1'b0;
    eval_next_grid = '0;
    eval_removed = '0;
    eval_any = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", eval_req, 0);
    chk("rst_total", total_removed, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Start before any load is ignored.
    go(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("noload_req", eval_req, 0);
    chk("noload_busy", busy, 0);

    // Full grid: corners go on pass 1, nothing on pass 2.
    load_grid(16'hFFFF);
    go(0, 0, 0, 0);
    chk("full_total", total_removed, 4);
    chk("full_pass", pass_count, 2);
    chk("full_err", err, 0);
    chk("full_done", done, 1);
    rd_force = 1;
    rd_val = 2'd0;
    @(posedge clk);
    #3;
    chk("full_row0", grid_rd_data, 4'h6);
    rd_force = 0;

    // Empty grid: a single zero-removal pass.
    load_grid(16'h0000);
    go(0, 0, 0, 2);
    chk("empty_total", total_removed, 0);
    chk("empty_pass", pass_count, 1);
    chk("empty_done", done, 1);

    // Stub datapath always removing one roll hits the pass limit.
    load_grid(16'($urandom));
    go(1, 1, 0, 2);
    chk("limit_total", total_removed, 3);
    chk("limit_pass", pass_count, 3);
    chk("limit_err", err, 1);

    // Large removal counts saturate the total.
    go(1, 20, 0, 1);
    chk("sat_total", total_removed, 31);
    chk("sat_err", err, 1);

    // Slow datapath: request and grid held for 5 cycles.
    load_grid(16'hFFFF);
    go(0, 0, 5, 5);
    chk("slow_total", total_removed, 4);

    // Row and start together in DONE with the grid loaded: both take effect.
    load_row(4'h9, 1, hon);
    chk("both_hon", hon, 1);
    if (hon) serve_run(0, 0, 0, 3);

    // Random grids with partial reloads and random ack delay.
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 4);
      hon = 0;
      for (int k = 0; k < n; k++) begin
        load_row(4'($urandom), (k == n-1) && ($urandom_range(0, 1) == 1), hon);
        if (hon) serve_run(0, 0, 0, 3);
      end
      if (!hon) go(0, 0, 0, 3);
    end

    // Reset in the middle of a pass, then a late ack.
    load_grid(16'hFFFF);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    phase = 1;
    tot_chk = 0;
    chk("mid_req", eval_req, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_busy", busy, 0);
    chk("async_req", eval_req, 0);
    chk("async_rd", grid_rd_data, 0);
    chk("async_pass", pass_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    eval_ack = 1'b1;
    eval_any = 1'b1;
    eval_removed = 5'd3;
    eval_next_grid = 16'hFFFF;
    @(posedge clk);
    #1;
    eval_ack = 1'b0;
    chk("late_busy", busy, 0);
    chk("late_total", total_removed, 0);
    chk("late_pass", pass_count, 0);

    // First load completing together with start: start ignored.
    for (int r = 0; r < D-1; r++) load_row(4'hF, 0, hon);
    load_row(4'hF, 1, hon);
    @(posedge clk);
    #1;
    chk("first_load_start", busy, 0);
    go(0, 0, 0, 1);
    chk("after_total", total_removed, 4);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/removal_sequencer.md
REMOVAL_SEQUENCER -- requirements
Module: removal_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: grid columns.
REQ-002 Parameter DEPTH, default 16: grid rows.
REQ-003 Parameter MAX_PASSES, default 64: evaluation pass limit; CW = $clog2(WIDTH*DEPTH+1), PW = $clog2(MAX_PASSES+1), RW = $clog2(DEPTH).
REQ-004 clk  in  1  the single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 row_valid  in  1  load row offered.
REQ-007 row_ready  out  1  load row accepted when row_valid && row_ready.
REQ-008 row_data  in  WIDTH  bit j = column j; 1 = paper roll, 0 = empty.
REQ-009 start  in  1  begin iterative removal on loaded grid.
REQ-010 busy  out  1  high in EVAL and UPDATE states.
REQ-011 done  out  1  run complete; level.
REQ-012 total_removed  out  CW  accumulated removals of current/last run.
REQ-013 pass_count  out  PW  evaluations completed, including final zero-removal pass.
REQ-014 err  out  1  pass limit reached or count saturated.
REQ-015 eval_req  out  1  request to removal datapath.
REQ-016 eval_grid  out  WIDTH*DEPTH  stored grid, row r at bits [r*WIDTH +: WIDTH].
REQ-017 eval_ack  in  1  datapath result valid.
REQ-018 eval_next_grid  in  WIDTH*DEPTH  grid after removing accessible rolls.
REQ-019 eval_removed  in  CW  rolls removed this pass.
REQ-020 eval_any  in  1  eval_removed nonzero.
REQ-021 grid_rd_row  in  RW  readback row select.
REQ-022 grid_rd_data  out  WIDTH  combinational read of stored row grid_rd_row.

Function
REQ-023 States: IDLE, EVAL, UPDATE, DONE; row_ready = 1 only in IDLE and DONE.
REQ-024 Load: accepted rows written in order 0..DEPTH-1 via row counter; counter wraps to 0 after DEPTH-1; loaded flag set on write of row DEPTH-1, stays set; any accepted row clears done and moves DONE->IDLE.
REQ-025 start in IDLE/DONE with loaded=1 -> total_removed=0, pass_count=0, err=0, done=0, next state EVAL; start with loaded=0 or while busy is ignored.
REQ-026 EVAL: eval_req=1, held until eval_ack; eval_grid stable throughout; eval_ack while eval_req=0 ignored.
REQ-027 On eval_ack in EVAL: pass_count+1; if eval_any=1: grid <= eval_next_grid, total_removed += eval_removed, then UPDATE; if eval_any=0: grid unchanged, go DONE.
REQ-028 UPDATE: one cycle, eval_req=0; if pass_count == MAX_PASSES -> err=1, DONE; else EVAL.
REQ-029 total_removed addition saturates at 2^CW-1; saturation sets err=1, run continues.
REQ-030 DONE: done=1, busy=0, eval_req=0; outputs hold until next start or accepted row.
REQ-031 Latency: start to first eval_req = 1 cycle; ack to next eval_req = 2 cycles.
REQ-032 Simultaneous start and row_valid in IDLE/DONE: row accepted, start honoured only if loaded already 1 before that edge.
REQ-033 Partial reload (fewer than DEPTH new rows) leaves remaining rows from previous grid; no error.

Reset
REQ-034 rst_n low -> state IDLE, grid all 0, row counter 0, loaded 0, busy 0, done 0, err 0, eval_req 0, total_removed 0, pass_count 0, immediately and independent of clk.
REQ-035 Reset mid-run abandons the pass; a subsequent eval_ack is ignored.

Verification (WIDTH=4, DEPTH=4, MAX_PASSES=3, reference datapath model unless stated)
REQ-036 Load four rows 4'hF, start -> pass 1 removes 4 corners, pass 2 removes 0; done=1, total_removed=4, pass_count=2, err=0, grid_rd_data row0=4'h6.
REQ-037 Load all-zero grid, start -> one pass, done=1, total_removed=0, pass_count=1.
REQ-038 Stub datapath always eval_any=1, eval_removed=1 -> done after 3 acks, err=1, total_removed=3, pass_count=3.
REQ-039 start before any load -> no eval_req, state IDLE; ack delayed 5 cycles -> eval_req and eval_grid stable all 5 cycles.
REQ-040 rst_n low during EVAL, late eval_ack after release -> all outputs zero, no state change.
